// File: rtl/approx_comparator_pipe_if.sv
// Handshake bundle for approx_comparator_pipe: operand channel, result channel
// and mismatch statistics.
interface approx_comparator_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_gt;
    logic             out_eq;
    logic             out_lt;
    logic             out_mode;
    logic [TAG_W-1:0] out_tag;
    logic             err_clr;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_tag, out_ready, err_clr,
        input  in_ready, out_valid, out_gt, out_eq, out_lt, out_mode, out_tag, err_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_tag, out_ready, err_clr,
        output in_ready, out_valid, out_gt, out_eq, out_lt, out_mode, out_tag, err_cnt
    );
endinterface

// File: rtl/approx_comparator_pipe.sv
// Two-stage pipelined unsigned magnitude comparator with exact/approximate mode.
// Optional mismatch statistics counter enabled by macro APPROX_ERR_STAT_EN.
module approx_comparator_pipe #(
    parameter int WIDTH       = 32,
    parameter int SEG_W       = 8,
    parameter int APPROX_BITS = 8,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    approx_comparator_pipe_if.slave   bus
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << APPROX_BITS;

    // Scan segments LSB to MSB so the most significant non-equal segment decides.
    function automatic logic [2:0] seg_combine(input logic [NSEG-1:0] gt,
                                               input logic [NSEG-1:0] eq);
        logic [2:0] res;
        res = 3'b010;
        for (int i = 0; i < NSEG; i++) begin
            res = eq[i] ? res : (gt[i] ? 3'b100 : 3'b001);
        end
        return res;
    endfunction

    logic [WIDTH-1:0] a_mask_s, b_mask_s;
    logic [NSEG-1:0]  seg_gt_s, seg_eq_s;
    logic             in_ready_s, s1_load_s, s2_load_s;

    logic             s1_valid_r, s1_mode_r;
    logic [NSEG-1:0]  s1_gt_r, s1_eq_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic             out_valid_r, out_gt_r, out_eq_r, out_lt_r, out_mode_r;
    logic [TAG_W-1:0] out_tag_r;

    assign in_ready_s = !s1_valid_r || !out_valid_r || bus.out_ready;
    assign s1_load_s  = bus.in_valid && in_ready_s;
    assign s2_load_s  = s1_valid_r && (!out_valid_r || bus.out_ready);

    // Clear the ignored LSBs of both operands in approximate mode.
    always_comb begin
        a_mask_s = bus.in_a;
        b_mask_s = bus.in_b;
        if (bus.in_mode) begin
            a_mask_s = bus.in_a & KEEP_MASK;
            b_mask_s = bus.in_b & KEEP_MASK;
        end else begin
            a_mask_s = bus.in_a;
            b_mask_s = bus.in_b;
        end
    end

    // Per-segment partial compares on the (possibly masked) operands.
    always_comb begin
        seg_gt_s = '0;
        seg_eq_s = '0;
        for (int i = 0; i < NSEG; i++) begin
            seg_gt_s[i] = a_mask_s[i*SEG_W +: SEG_W] > b_mask_s[i*SEG_W +: SEG_W];
            seg_eq_s[i] = a_mask_s[i*SEG_W +: SEG_W] == b_mask_s[i*SEG_W +: SEG_W];
        end
    end

    // Stage 1: segment flags, mode and tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_gt_r    <= '0;
            s1_eq_r    <= '0;
            s1_mode_r  <= 1'b0;
            s1_tag_r   <= '0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= bus.in_valid;
            end
            if (s1_load_s) begin
                s1_gt_r   <= seg_gt_s;
                s1_eq_r   <= seg_eq_s;
                s1_mode_r <= bus.in_mode;
                s1_tag_r  <= bus.in_tag;
            end
        end
    end

    // Stage 2: output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_gt_r    <= 1'b0;
            out_eq_r    <= 1'b0;
            out_lt_r    <= 1'b0;
            out_mode_r  <= 1'b0;
            out_tag_r   <= '0;
        end else begin
            if (!out_valid_r || bus.out_ready) begin
                out_valid_r <= s1_valid_r;
            end
            if (s2_load_s) begin
                {out_gt_r, out_eq_r, out_lt_r} <= seg_combine(s1_gt_r, s1_eq_r);
                out_mode_r <= s1_mode_r;
                out_tag_r  <= s1_tag_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_gt    = out_gt_r;
    assign bus.out_eq    = out_eq_r;
    assign bus.out_lt    = out_lt_r;
    assign bus.out_mode  = out_mode_r;
    assign bus.out_tag   = out_tag_r;

`ifdef APPROX_ERR_STAT_EN
    logic [NSEG-1:0]  xseg_gt_s, xseg_eq_s;
    logic [NSEG-1:0]  s1_xgt_r, s1_xeq_r;
    logic [2:0]       out_xres_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             mismatch_s;

    // Unmasked segment compares used only to score approximation errors.
    always_comb begin
        xseg_gt_s = '0;
        xseg_eq_s = '0;
        for (int i = 0; i < NSEG; i++) begin
            xseg_gt_s[i] = bus.in_a[i*SEG_W +: SEG_W] > bus.in_b[i*SEG_W +: SEG_W];
            xseg_eq_s[i] = bus.in_a[i*SEG_W +: SEG_W] == bus.in_b[i*SEG_W +: SEG_W];
        end
    end

    assign mismatch_s = out_valid_r && bus.out_ready && out_mode_r &&
                        (out_xres_r != {out_gt_r, out_eq_r, out_lt_r});

    // Exact-path shadow registers travelling alongside the main pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_xgt_r   <= '0;
            s1_xeq_r   <= '0;
            out_xres_r <= 3'b000;
        end else begin
            if (s1_load_s) begin
                s1_xgt_r <= xseg_gt_s;
                s1_xeq_r <= xseg_eq_s;
            end
            if (s2_load_s) begin
                out_xres_r <= seg_combine(s1_xgt_r, s1_xeq_r);
            end
        end
    end

    // Saturating mismatch counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (bus.err_clr) begin
            err_cnt_r <= '0;
        end else if (mismatch_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.err_cnt = err_cnt_r;
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = bus.err_clr;
    assign bus.err_cnt      = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_approx_comparator_pipe.sv
// Scoreboard bench for approx_comparator_pipe: directed cases plus randomized
// traffic with random backpressure, checked against an arithmetic reference.
module tb_approx_comparator_pipe;
    localparam int WIDTH = 32, SEG_W = 8, APPROX_BITS = 8, TAG_W = 4, CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0]       res;
        logic [2:0]       xres;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_comparator_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    approx_comparator_pipe #(
        .WIDTH(WIDTH), .SEG_W(SEG_W), .APPROX_BITS(APPROX_BITS), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   err_model = 0;
    logic held_v = 1'b0;
    logic [7:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: approximate mode simply discards the low bits by shifting.
    function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic approx);
        logic [WIDTH-1:0] x, y;
        x = approx ? (a >> APPROX_BITS) : a;
        y = approx ? (b >> APPROX_BITS) : b;
        if (x > y) return 3'b100;
        else if (x == y) return 3'b010;
        else return 3'b001;
    endfunction

    // One clock cycle: drive after the edge, check in_ready, record acceptance.
    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic m, input logic [TAG_W-1:0] t, input logic r, input logic c,
                        output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_mode   = m;
        bus.in_tag    = t;
        bus.out_ready = r;
        bus.err_clr   = c;
        #2;
        check("in_ready", bus.in_ready, (sb.size() < 2) || r);
        acc = v && bus.in_ready;
        if (acc) begin
            e.res  = ref_cmp(a, b, m);
            e.xres = ref_cmp(a, b, 1'b0);
            e.mode = m;
            e.tag  = t;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic r);
        logic acc;
        step(1'b0, '0, '0, 1'b0, '0, r, 1'b0, acc);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m,
                        input logic [TAG_W-1:0] t, input logic r);
        logic acc;
        int n;
        n = 0;
        do begin
            step(1'b1, a, b, m, t, r, 1'b0, acc);
            n++;
        end while (!acc && n < 50);
        check("send_accept", acc, 1);
    endtask

    // Monitor: pops and compares on every fire, checks stall stability and err_cnt.
    always @(negedge clk) begin
        exp_t e;
        logic fire;
        if (!rst) begin
            check("err_cnt", bus.err_cnt, err_model);
            fire = bus.out_valid && bus.out_ready;
            if (bus.out_valid) begin
                check("onehot", $countones({bus.out_gt, bus.out_eq, bus.out_lt}), 1);
                check("valid_pending", sb.size() != 0, 1);
                if (held_v)
                    check("stall_hold", {bus.out_gt, bus.out_eq, bus.out_lt, bus.out_mode, bus.out_tag}, held);
            end
            if (fire && sb.size() != 0) begin
                e = sb.pop_front();
                check("result", {bus.out_gt, bus.out_eq, bus.out_lt}, e.res);
                check("mode", bus.out_mode, e.mode);
                check("tag", bus.out_tag, e.tag);
`ifdef APPROX_ERR_STAT_EN
                if (!bus.err_clr && e.mode && (e.res != e.xres) && err_model < CNT_MAX)
                    err_model++;
`endif
            end
`ifdef APPROX_ERR_STAT_EN
            if (bus.err_clr) err_model = 0;
`endif
            held_v = bus.out_valid && !bus.out_ready;
            held   = {bus.out_gt, bus.out_eq, bus.out_lt, bus.out_mode, bus.out_tag};
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic pv, pr, pc, pm;
        logic [WIDTH-1:0] pa, pb;
        logic [TAG_W-1:0] pt;
        int n;

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = 1'b0;
        bus.in_tag = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_flags", {bus.out_gt, bus.out_eq, bus.out_lt, bus.out_mode}, 0);
        check("rst_tag", bus.out_tag, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1);

        // Exact compare with latency check
        send(32'h00001234, 32'h00001233, 1'b0, 4'd5, 1'b1);
        idle(1'b1);
        check("t1_lat_early", bus.out_valid, 0);
        idle(1'b1);
        check("t1_lat_valid", bus.out_valid, 1);
        check("t1_gt", bus.out_gt, 1);
        check("t1_tag", bus.out_tag, 5);

        // Approximate and boundary compares
        send(32'h00001234, 32'h00001233, 1'b1, 4'd6, 1'b1);
        send(32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd7, 1'b1);
        send(32'h00000000, 32'h00000100, 1'b1, 4'd8, 1'b1);
        send(32'h00000000, 32'h00000000, 1'b0, 4'd9, 1'b1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd10, 1'b1);
        send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd11, 1'b1);
        send(32'h000000FF, 32'h00000001, 1'b1, 4'd12, 1'b1);
        repeat (4) idle(1'b1);

        // Backpressure: pipe fills at two, output holds tag 0
        send(32'h10, 32'h20, 1'b0, 4'd0, 1'b0);
        send(32'h30, 32'h30, 1'b0, 4'd1, 1'b0);
        step(1'b1, 32'h500, 32'h400, 1'b1, 4'd2, 1'b0, 1'b0, acc);
        check("t4_blocked", acc, 0);
        check("t4_tag0", bus.out_tag, 0);
        step(1'b1, 32'h500, 32'h400, 1'b1, 4'd2, 1'b0, 1'b0, acc);
        check("t4_tag0_hold", bus.out_tag, 0);
        send(32'h500, 32'h400, 1'b1, 4'd2, 1'b1);
        send(32'h1, 32'h2, 1'b0, 4'd3, 1'b1);
        repeat (4) idle(1'b1);

        // Reset with both stages occupied
        send(32'h1234, 32'h1233, 1'b1, 4'd4, 1'b0);
        send(32'h9, 32'h8, 1'b0, 4'd5, 1'b0);
        idle(1'b0);
        check("pre_reset_full", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_err_cnt", bus.err_cnt, 0);
        sb.delete();
        err_model = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        repeat (5) idle(1'b1);

`ifdef APPROX_ERR_STAT_EN
        // Clear coincident with a mismatching fire, then saturation
        send(32'h1234, 32'h1233, 1'b1, 4'd1, 1'b1);
        idle(1'b1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, acc);
        idle(1'b1);
        check("t6_clr_priority", bus.err_cnt, 0);
        for (int i = 0; i < CNT_MAX + 4; i++)
            send(32'h00000001, 32'h00000000, 1'b1, i[TAG_W-1:0], 1'b1);
        repeat (4) idle(1'b1);
        check("t6_saturate", bus.err_cnt, CNT_MAX);
`endif

        // Randomized traffic with random backpressure
        pa = $urandom; pb = $urandom; pm = 1'b0; pt = '0;
        for (int i = 0; i < 1500; i++) begin
            pv = ($urandom_range(0, 9) < 7);
            pr = ($urandom_range(0, 9) < 7);
            pc = ($urandom_range(0, 49) == 0);
            step(pv, pa, pb, pm, pt, pr, pc, acc);
            if (acc) begin
                pa = $urandom;
                case ($urandom_range(0, 3))
                    0:       pb = pa;
                    1:       pb = pa ^ WIDTH'($urandom_range(0, 255));
                    2:       pb = pa ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                    default: pb = $urandom;
                endcase
                pm = $urandom_range(0, 1);
                pt = pt + 4'd1;
            end
        end

        // Drain
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        check("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/approx_comparator_pipe.md
Name: approx_comparator_pipe

Overview:
Parametrised, pipelined successor to the 32-bit approximate magnitude comparator. It compares two unsigned WIDTH-bit operands per transaction and returns one-hot gt/eq/lt. Each transaction selects exact mode or approximate mode; approximate mode ignores the APPROX_BITS least-significant bits. The block sits between operand producers and datapath consumers, with valid/ready handshakes and backpressure on both sides.

Parameters:
WIDTH, 32, operand width; must be a multiple of SEG_W.
SEG_W, 8, segment width for the stage-1 partial compares.
APPROX_BITS, 8, number of LSBs ignored in approximate mode; range 0..WIDTH-1.
TAG_W, 4, width of the user tag carried alongside each transaction.
CNT_W, 16, width of the mismatch statistics counter.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operands valid.
in_ready  out  1  block can accept operands.
in_a  in  WIDTH  operand A, unsigned.
in_b  in  WIDTH  operand B, unsigned.
in_mode  in  1  0 = exact, 1 = approximate.
in_tag  in  TAG_W  user tag, echoed on the output.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_gt  out  1  A > B.
out_eq  out  1  A == B; in approximate mode, the upper bits are equal.
out_lt  out  1  A < B.
out_mode  out  1  mode of the result.
out_tag  out  TAG_W  tag of the result.
err_clr  in  1  synchronous clear of err_cnt.
err_cnt  out  CNT_W  saturating count of approximate/exact mismatches.

Behaviour:
- Reset (async, active-high): s1_valid, out_valid, out_gt, out_eq, out_lt, out_mode, out_tag and err_cnt all go to 0 immediately. in_ready = 1 while the pipe is empty after reset release. Any in-flight transactions are discarded.
- Accept: a transaction is accepted on a rising edge where in_valid && in_ready.
- Fire: a result is delivered on a rising edge where out_valid && out_ready.
- Masking: if in_mode = 1, bits [APPROX_BITS-1:0] of both operands are forced to 0 before stage 1. If in_mode = 0, or APPROX_BITS = 0, the full-width compare is used.
- Stage 1 (registered): for each of the WIDTH/SEG_W segments, register seg_gt[i] and seg_eq[i]. Also register mode and tag. Capture the unmasked segment flags too, but only when the feature below is enabled.
- Stage 2 (output register): priority-combine the segments from the MSB segment down.
  - gt = first non-equal segment has seg_gt set.
  - eq = all segments equal.
  - lt = otherwise.
  - Exactly one of gt/eq/lt is 1 whenever out_valid = 1.
- Latency: 2 cycles from accept to out_valid, with no stalls. Throughput: 1 transaction per cycle. Capacity: 2 transactions.
- Flow control:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready. This is combinational from out_ready, with no combinational path from in_valid.
- Stall: while out_valid && !out_ready, all out_* signals hold stable.
- Simultaneous fire and load: the output register takes the new result with no bubble.
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- Outputs with out_valid = 0: gt/eq/lt retain their last values; the bench ignores them.
- Boundaries: operands 0 vs 0 give eq. All-ones vs all-ones give eq. MSB-only differences are resolved by segment WIDTH/SEG_W-1.

Optional Feature:
Macro APPROX_ERR_STAT_EN.
- Defined:
  - Stage 1 additionally computes exact (unmasked) segment flags, and stage 2 registers the exact one-hot result internally.
  - On each fire of a mode = 1 result whose approximate gt/eq/lt differs from the exact result, err_cnt increments by 1.
  - err_cnt saturates at 2^CNT_W-1.
  - err_clr forces err_cnt to 0 on the next edge and takes priority over a simultaneous increment.
- Not defined: err_cnt is tied to 0, err_clr is ignored, and no exact-path logic is instantiated. Port list is unchanged.

Test Plan:
1. Exact mode: WIDTH=32, APPROX_BITS=8, A=0x00001234, B=0x00001233, mode=0, tag=5, out_ready=1 -> out_valid 2 cycles later with gt=1, eq=0, lt=0, tag=5.
2. Approximate mode: same operands, mode=1 -> eq=1. With APPROX_ERR_STAT_EN, err_cnt goes from 0 to 1 on fire.
3. Approximate mode: A=0x80000000, B=0x7FFFFFFF -> gt=1. A=0, B=0x00000100 -> lt=1. err_cnt unchanged by both.
4. Backpressure: issue 4 back-to-back transactions with tags 0..3 while out_ready=0 -> in_ready drops to 0 after 2 accepts and out_* hold tag 0 stable. Then raise out_ready -> tags 0,1,2,3 emerge on consecutive cycles with correct results.
5. Reset mid-operation: with both stages valid, assert rst asynchronously -> out_valid=0 and err_cnt=0 before the next clk edge. After release, in_ready=1 and no stale results appear.
6. With APPROX_ERR_STAT_EN: err_clr asserted on the same edge as a mismatching fire -> err_cnt=0. Then force 2^16+3 mismatches -> err_cnt saturates at 0xFFFF.
